cam_capture_ctrl: RTL and testbench

//  Write-side controller for the dual-port frame buffer, clocked by the camera pixel clock.

---
 rtl/cam_pkg.sv | 36 +++
 rtl/rgb565_pack.sv | 44 ++++
 rtl/cam_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM encoding, image geometry
// defaults and the RGB111 bit layout also used by the read-side filter.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYNC,
        ST_CAP,
        ST_DONE
    } state_e;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;

    localparam int RGB_R_BIT = 2;
    localparam int RGB_G_BIT = 1;
    localparam int RGB_B_BIT = 0;

    typedef logic [2:0] rgb111_t;

    function automatic int img_npix(input int w, input int h);
        return w * h;
    endfunction

    // Keep only the MSB of each RGB565 channel: R5 from byte1[7], G6 from byte1[2], B5 from byte2[4].
    function automatic rgb111_t pack_rgb111(input logic [7:0] byte1, input logic [7:0] byte2);
        rgb111_t p;
        p            = '0;
        p[RGB_R_BIT] = byte1[7];
        p[RGB_G_BIT] = byte1[2];
        p[RGB_B_BIT] = byte2[4];
        return p;
    endfunction

endpackage

// File: rtl/rgb565_pack.sv
// Byte-pair assembler: tracks the byte phase within a line, holds the first byte
// and presents one RGB111 pixel when the second byte arrives.
module rgb565_pack
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pix_valid,
    output rgb111_t    pix
);

    logic       phase_q, phase_d;
    logic [7:0] byte1_q, byte1_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        phase_d = 1'b0;
        byte1_d = byte1_q;
        if (en && href) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                byte1_d = data;
            end
        end
    end

    assign pix_valid = en && href && phase_q;
    assign pix       = pack_rgb111(byte1_q, data);

    // NOTE: reset is synchronous and active-low, so rst is only looked at inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= 1'b0;
            byte1_q <= '0;
        end else begin
            phase_q <= phase_d;
            byte1_q <= byte1_d;
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Write-side frame buffer controller on the camera pixel clock: frame sequencing,
// pixel packing, write address generation and capture status.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 3,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    cam_data,
    input  logic          start,
    input  logic          mode_cont,
    input  logic          abort,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          ovf_err
);

    localparam int            NPIX     = img_npix(IMG_W, IMG_H);
    localparam logic [AW:0]   NPIX_C   = (AW+1)'(NPIX);
    localparam logic [AW-1:0] ADDR_MAX = AW'(NPIX - 1);

    state_e        state_q, state_d;
    logic          r_vsync_q, r_href_q, vsync_prev_q;
    logic [7:0]    r_data_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic          regwrite_q, regwrite_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          ovf_q, ovf_d;

    logic          pix_valid;
    rgb111_t       pix;

    rgb565_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == ST_CAP),
        .href      (r_href_q),
        .data      (r_data_q),
        .pix_valid (pix_valid),
        .pix       (pix)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        data_d       = data_q;
        regwrite_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ovf_d        = ovf_q;

        // Writes are never back-to-back, so the address steps once after each write.
        if (regwrite_q && addr_q != ADDR_MAX) begin
            addr_d = addr_q + AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start || mode_cont) begin
                    state_d = ST_ARM;
                    ovf_d   = 1'b0;
                end
            end
            ST_ARM: begin
                if (r_vsync_q) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                addr_d = '0;
                idx_d  = '0;
                if (!r_vsync_q) state_d = ST_CAP;
            end
            ST_CAP: begin
                if (pix_valid) begin
                    if (idx_q < NPIX_C) begin
                        regwrite_d = 1'b1;
                        data_d     = pix;
                        idx_d      = idx_q + (AW+1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (r_vsync_q && !vsync_prev_q) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = mode_cont ? ST_SYNC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a frame end seen in the same cycle.
        if (abort) begin
            state_d      = ST_IDLE;
            regwrite_d   = 1'b0;
            frame_done_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            r_vsync_q    <= 1'b0;
            r_href_q     <= 1'b0;
            r_data_q     <= '0;
            vsync_prev_q <= 1'b0;
            addr_q       <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            regwrite_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_vsync_q    <= vsync;
            r_href_q     <= href;
            r_data_q     <= cam_data;
            vsync_prev_q <= r_vsync_q;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            regwrite_q   <= regwrite_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign regwrite   = regwrite_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl on a 4x2 frame: stimulus pushes expected
// buffer writes into a queue, a negedge monitor pops and compares each write.
module tb_cam_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 3;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          start = 1'b0;
    logic          mode_cont = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          ovf_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests   = 0;
    int  n_fail    = 0;
    int  exp_idx   = 0;
    int  done_seen = 0;
    int  wr_seen   = 0;

    cam_capture_ctrl #(
        .AW    (AW),
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .start      (start),
        .mode_cont  (mode_cont),
        .abort      (abort),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_pix(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7], b1[2], b2[4]};
    endfunction

    task automatic push_exp(input logic [7:0] b1, input logic [7:0] b2);
        wr_t e;
        if (exp_idx < NPIX) begin
            e.addr = AW'(exp_idx);
            e.data = exp_pix(b1, b2);
            exp_q.push_back(e);
        end
        exp_idx++;
    endtask

    task automatic vs(input logic v, input int n);
        vsync = v;
        href  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pairs(input logic [7:0] b1, input logic [7:0] b2, input int n, input bit expect_wr);
        for (int i = 0; i < n; i++) begin
            href     = 1'b1;
            cam_data = b1;
            @(negedge clk);
            cam_data = b2;
            if (expect_wr) push_exp(b1, b2);
            @(negedge clk);
        end
    endtask

    task automatic odd_byte(input logic [7:0] b);
        href     = 1'b1;
        cam_data = b;
        @(negedge clk);
    endtask

    task automatic line_end();
        href     = 1'b0;
        cam_data = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},     32'(addr_in),    32'd0);
        check({tag, "_data"},     32'(data_in),    32'd0);
        check({tag, "_regwrite"}, 32'(regwrite),   32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_done"},     32'(frame_done), 32'd0);
        check({tag, "_cnt"},      32'(frame_cnt),  32'd0);
        check({tag, "_ovf"},      32'(ovf_err),    32'd0);
    endtask

    // Monitor: every buffer write must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (regwrite) begin
                    wr_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_addr", 32'(addr_in), 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(addr_in), 32'(e.addr));
                        check("wr_data", 32'(data_in), 32'(e.data));
                    end
                end
                if (frame_done) done_seen++;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Snapshot of a full 4x2 frame.
        pulse_start();
        check("t1_busy_armed", 32'(busy), 32'd1);
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        repeat (2) begin
            send_pairs(8'hF8, 8'h1F, 4, 1'b1);
            line_end();
        end
        vs(1'b1, 3);
        vs(1'b0, 3);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_done_pulses", 32'(done_seen), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_writes", 32'(wr_seen), 32'd8);

        // start arrives mid-frame: nothing is written until the next vsync fall.
        send_pairs(8'hF8, 8'h1F, 1, 1'b0);
        start = 1'b1;
        send_pairs(8'hF8, 8'h1F, 1, 1'b0);
        start = 1'b0;
        send_pairs(8'hF8, 8'h1F, 2, 1'b0);
        line_end();
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_no_writes", 32'(wr_seen), 32'd8);
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        send_pairs(8'h84, 8'h00, 4, 1'b1);
        line_end();
        vs(1'b1, 3);
        vs(1'b0, 3);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
        check("t2_idle", 32'(busy), 32'd0);

        // Continuous capture over three short frames; mode_cont dropped in the last one.
        mode_cont = 1'b1;
        vs(1'b1, 3);
        for (int f = 0; f < 3; f++) begin
            vs(1'b0, 3);
            exp_idx = 0;
            if (f == 2) mode_cont = 1'b0;
            send_pairs(8'h04, 8'h10, 4, 1'b1);
            line_end();
            vs(1'b1, 3);
        end
        vs(1'b0, 3);
        check("t3_frame_cnt", 32'(frame_cnt), 32'd5);
        check("t3_done_pulses", 32'(done_seen), 32'd5);
        check("t3_idle", 32'(busy), 32'd0);

        // Overflow: NPIX+5 pixels in one frame.
        pulse_start();
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        repeat (3) begin
            send_pairs(8'hFF, 8'hFF, 4, 1'b1);
            line_end();
        end
        send_pairs(8'hFF, 8'hFF, 1, 1'b1);
        line_end();
        vs(1'b1, 3);
        vs(1'b0, 3);
        check("t4_ovf_set", 32'(ovf_err), 32'd1);
        check("t4_addr_sat", 32'(addr_in), 32'(NPIX - 1));
        check("t4_writes", 32'(wr_seen), 32'd32);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd6);
        repeat (3) @(negedge clk);
        check("t4_ovf_held", 32'(ovf_err), 32'd1);
        pulse_start();
        check("t4_ovf_cleared", 32'(ovf_err), 32'd0);
        check("t4_busy_armed", 32'(busy), 32'd1);

        // Odd byte count: trailing byte dropped, next line starts on phase 0.
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        send_pairs(8'hF8, 8'h1F, 1, 1'b1);
        send_pairs(8'h84, 8'h00, 1, 1'b1);
        odd_byte(8'hFF);
        line_end();
        send_pairs(8'h80, 8'h00, 4, 1'b1);
        line_end();
        vs(1'b1, 3);
        vs(1'b0, 3);
        check("t5_writes", 32'(wr_seen), 32'd38);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd7);

        // Abort after three pixels.
        pulse_start();
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        send_pairs(8'hF8, 8'h1F, 3, 1'b1);
        line_end();
        check("t6_busy_cap", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_abort_idle", 32'(busy), 32'd0);
        vs(1'b1, 3);
        vs(1'b0, 3);
        check("t6_abort_cnt", 32'(frame_cnt), 32'd7);
        check("t6_abort_no_done", 32'(done_seen), 32'd7);
        check("t6_abort_writes", 32'(wr_seen), 32'd41);

        // Reset in the middle of a capture.
        pulse_start();
        vs(1'b1, 3);
        vs(1'b0, 3);
        exp_idx = 0;
        send_pairs(8'h84, 8'h00, 2, 1'b1);
        line_end();
        href     = 1'b1;
        cam_data = 8'hF8;
        rst      = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst  = 1'b1;
        href = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", 32'(busy), 32'd0);
        check("final_writes", 32'(wr_seen), 32'd43);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
